// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB bus encodings and burst helpers for the arbiter
package ahb_pkg;

  localparam int BEAT_CNT_W = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } hresp_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // SINGLE and INCR report 1: neither pins the bus beyond the current beat.
  function automatic logic [4:0] burst_len(hburst_e b);
    case (b)
      HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
      default:                      burst_len = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// rtl/ahb_rr_picker.sv - rotating-priority request picker, last grant gets lowest priority
module ahb_rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         valid
);

  // Scan from the farthest offset down so the nearest requester after 'last' wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int off = N; off >= 1; off--) begin
      int idx;
      idx = (int'(last) + off) % N;
      if (req[idx]) begin
        winner = W'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// rtl/ahb_bus_arbiter.sv - round-robin AHB arbiter holding the bus across fixed bursts and locks
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int N_MASTERS  = 4,
  parameter int DEF_MASTER = 0,
  parameter int MW         = $clog2(N_MASTERS)
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [N_MASTERS-1:0] HBUSREQ,
  input  logic [N_MASTERS-1:0] HLOCK,
  input  logic [1:0]           HTRANS,
  input  logic [2:0]           HBURST,
  input  logic                 HREADY,
  input  logic [1:0]           HRESP,
  output logic [N_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]        HMASTER,
  output logic                 HMASTLOCK
);

  localparam logic [N_MASTERS-1:0] DEF_GRANT = {{(N_MASTERS-1){1'b0}}, 1'b1} << DEF_MASTER;
  localparam logic [MW-1:0]        DEF_IDX   = MW'(DEF_MASTER);

  arb_state_e             state, state_next;
  logic [BEAT_CNT_W-1:0]  cnt, cnt_next, cnt_load;
  logic [4:0]             len_m1;
  logic [MW-1:0]          gnt_idx, gnt_idx_next, pick_idx;
  logic [N_MASTERS-1:0]   grant_next;
  logic                   pick_valid, err, lock_hold, regrant;
  htrans_e                trans;

  assign trans    = htrans_e'(HTRANS);
  assign err      = !HREADY && (hresp_e'(HRESP) != HRESP_OKAY);
  assign len_m1   = burst_len(hburst_e'(HBURST)) - 5'd1;
  assign cnt_load = len_m1[BEAT_CNT_W-1:0];

  ahb_rr_picker #(.N(N_MASTERS), .W(MW)) u_picker (
    .req    (HBUSREQ),
    .last   (gnt_idx),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    cnt_next     = cnt;
    state_next   = state;
    gnt_idx_next = gnt_idx;
    lock_hold    = HLOCK[gnt_idx] | HMASTLOCK;

    // Any non-OKAY response cancels the remaining beats, SPLIT included.
    if (err) begin
      cnt_next = '0;
    end else if (HREADY) begin
      case (trans)
        HTRANS_NONSEQ: cnt_next = cnt_load;
        HTRANS_SEQ:    if (cnt != '0) cnt_next = cnt - BEAT_CNT_W'(1);
        default:       cnt_next = cnt;
      endcase
    end

    if (HREADY) begin
      if (lock_hold)            state_next = LOCKED;
      else if (cnt_next != '0)  state_next = BURST;
      else                      state_next = ARB;
    end else if (err && state == BURST) begin
      state_next = ARB;
    end

    regrant = HREADY && (state_next == ARB);
    if (regrant) gnt_idx_next = pick_valid ? pick_idx : DEF_IDX;
    grant_next = {{(N_MASTERS-1){1'b0}}, 1'b1} << gnt_idx_next;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ARB;
      cnt       <= '0;
      gnt_idx   <= DEF_IDX;
      HGRANT    <= DEF_GRANT;
      HMASTER   <= DEF_IDX;
      HMASTLOCK <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      gnt_idx <= gnt_idx_next;
      HGRANT  <= grant_next;
      // Ownership and lock follow the grant one accepted cycle later.
      if (HREADY) begin
        HMASTER   <= gnt_idx;
        HMASTLOCK <= HLOCK[gnt_idx];
      end
    end
  end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Multi-master AHB arbiter for the shared AHB3 bus (HTRANS/HBURST/HSIZE/HADDR/HWDATA/HWRITE, HREADY, 2-bit HRESP).
- Takes per-master HBUSREQ/HLOCK and drives one-hot HGRANT, the HMASTER address-phase owner index (select for the master-side address/data mux), and HMASTLOCK.
- Uses round-robin priority and never re-arbitrates inside a fixed-length burst or a locked sequence.

Parameters:
- N_MASTERS, 4, number of requesting masters (2..16).
- DEF_MASTER, 0, master granted when no request is pending.
- MW, $clog2(N_MASTERS), width of HMASTER.

Ports:
- HCLK  input  1  bus clock, all state on rising edge.
- HRESETn  input  1  reset, asynchronous, active-low.
- HBUSREQ  input  N_MASTERS  bus request per master.
- HLOCK  input  N_MASTERS  locked-access request per master.
- HTRANS  input  2  shared bus transfer type (0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ).
- HBURST  input  3  shared bus burst type (0 SINGLE, 1 INCR, 2/3 x4, 4/5 x8, 6/7 x16).
- HREADY  input  1  shared bus ready.
- HRESP  input  2  shared bus response (0 OKAY, 1 ERROR, 2 RETRY, 3 SPLIT).
- HGRANT  output  N_MASTERS  one-hot grant, registered.
- HMASTER  output  MW  index of the master owning the address phase, registered.
- HMASTLOCK  output  1  current address phase is locked, registered.

Behaviour:
- Reset (async assert, sync release):
  - HGRANT = 1<<DEF_MASTER, HMASTER = DEF_MASTER, HMASTLOCK = 0.
  - Beat counter cnt = 0, state ARB.
  - Reset mid-burst aborts the burst with no residual state.
- Beat counter (cnt = address beats still owed by the current burst), updated only on edges with HREADY=1:
  - NONSEQ with fixed burst (HBURST 2..7): cnt <= len-1, where len is 4, 8 or 16.
  - NONSEQ with SINGLE or INCR: cnt <= 0.
  - SEQ with cnt>0: cnt <= cnt-1.
  - IDLE and BUSY: cnt unchanged.
  - cnt width is 4 bits. It never underflows: SEQ with cnt=0 holds at 0.
- Early termination: any cycle with HREADY=0 and HRESP != OKAY forces cnt <= 0. SPLIT is treated as RETRY (no HSPLIT support).
- Lock:
  - At each HREADY=1 edge, HMASTLOCK <= HLOCK[granted index].
  - lock_hold = HLOCK[granted] | HMASTLOCK, so the grant is held for one transfer after HLOCK drops.
- States:
  - ARB: cnt_next==0 and !lock_hold.
  - BURST: cnt_next>0 and !lock_hold.
  - LOCKED: lock_hold.
  - Transitions follow these conditions every HREADY=1 edge. The state is held while HREADY=0, except that an error response forces BURST→ARB.
- Grant update:
  - HGRANT may change only on a rising edge where HREADY=1 and the state being entered is ARB. This includes the edge that accepts the last beat of a fixed burst.
  - Winner: rotating priority starting at (current grant index+1) mod N_MASTERS. The current holder has the lowest priority, so it keeps the grant only if it is the sole requester.
  - No HBUSREQ asserted → grant DEF_MASTER.
- Ownership: HMASTER <= granted index on every edge with HREADY=1; it lags HGRANT by one accepted cycle.
- Handover latency:
  - A new grant is visible the cycle after the last beat is accepted.
  - The new master's NONSEQ appears at the earliest one cycle later; the old owner drives IDLE in between.
- INCR (undefined length) and SINGLE: re-arbitration is possible on every accepted beat.
- Invariants: HGRANT is always exactly one-hot. No combinational path from inputs to outputs.

Decomposition:
- ahb_pkg holds:
  - enums htrans_e, hburst_e, hresp_e;
  - function burst_len(hburst_e) returning 1/4/8/16;
  - constant BEAT_CNT_W = 4.
- Sub-module ahb_rr_picker: combinational rotating-priority encoder. Inputs: request vector and last grant index. Outputs: winner index and a valid flag.

Test Plan:
- Reset: assert HRESETn=0 mid INCR8 at cnt=5 → outputs immediately HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0; after release, a master-2 request is granted in 1 edge.
- Round robin: HBUSREQ=4'b1110 held, back-to-back SINGLE NONSEQ, HREADY=1 → HGRANT sequence 0010, 0100, 1000, 0010; HMASTER follows one edge later.
- Burst hold: master 2 issues INCR4 with HBUSREQ=4'b1111 and HREADY=0 for 2 cycles on beat 2 → HGRANT stays 0100 until the edge accepting beat 4, then becomes 1000.
- Lock: master 1 with HLOCK=1 issues 3 SINGLEs while HBUSREQ[3]=1 → HGRANT stays 0010 and HMASTLOCK=1; HLOCK drops → one more transfer by master 1, then HGRANT=1000 and HMASTLOCK=0.
- Error abort: master 3 in INCR16 gets ERROR (HREADY=0, HRESP=1) on beat 3 while HBUSREQ[0]=1 → cnt=0, and HGRANT=0001 on the next HREADY=1 edge.
- Idle/BUSY: INCR8 with 3 BUSY cycles inserted → cnt is not decremented by BUSY and the grant is held for all 8 beats; then all requests drop → HGRANT returns to 1<<DEF_MASTER.
